run_controller: RTL and testbench

//  Upstream harness stage for the 9-bit core: streams a program into instruction memory, then runs the core.

---
 rtl/run_controller.sv | 161 ++++++++++++++++
 tb/tb_run_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// rtl/run_controller.sv - program loader and run supervisor for the 9-bit core
module run_controller #(
  parameter int instr_width  = 9,
  parameter int imem_depth   = 256,
  parameter int start_cycles = 2,
  parameter int max_cycles   = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [instr_width-1:0]          load_data,
  input  logic                            load_last,
  output logic                            imem_we,
  output logic [$clog2(imem_depth)-1:0]   imem_addr,
  output logic [instr_width-1:0]          imem_wdata,
  output logic [$clog2(imem_depth):0]     prog_len,
  input  logic                            go,
  output logic                            start,
  input  logic                            halt,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic [15:0]                     cycle_count
);

  localparam int ia_w = $clog2(imem_depth);
  localparam int sc_w = (start_cycles > 1) ? $clog2(start_cycles) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, READY, START, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ia_w-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ia_w:0]          prog_len_q, prog_len_d;
  logic                   loaded_q, loaded_d;
  // term_q blocks load_ready for the single cycle after a load ends
  logic                   term_q, term_d;
  logic                   we_q, we_d;
  logic [ia_w-1:0]        addr_q, addr_d;
  logic [instr_width-1:0] wdata_q, wdata_d;
  logic [sc_w-1:0]        sc_q, sc_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic                   accept_state;
  logic                   beat;
  logic [ia_w-1:0]        addr_cur;

  // Output decode from the state register so reset clears start at once
  always_comb begin
    accept_state = (state_q == IDLE) || (state_q == LOAD) ||
                   (state_q == READY) || (state_q == DONE);
    load_ready   = accept_state && !term_q;
    beat         = load_valid && load_ready;
    addr_cur     = (state_q == LOAD) ? wr_ptr_q : '0;
    start        = (state_q == START);
    busy         = (state_q == LOAD) || (state_q == START) || (state_q == RUN);
    done         = (state_q == DONE);
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign prog_len    = prog_len_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

  // Next-state: a load beat always takes priority over go
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    loaded_d   = loaded_q;
    term_d     = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sc_d       = sc_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    if (beat) begin
      we_d     = 1'b1;
      addr_d   = addr_cur;
      wdata_d  = load_data;
      wr_ptr_d = addr_cur + ia_w'(1);
      if (state_q != LOAD) begin
        loaded_d  = 1'b0;
        timeout_d = 1'b0;
        cnt_d     = '0;
      end
      if (load_last || (addr_cur == ia_w'(imem_depth - 1))) begin
        state_d    = READY;
        prog_len_d = {1'b0, addr_cur} + (ia_w+1)'(1);
        loaded_d   = 1'b1;
        term_d     = 1'b1;
      end else begin
        state_d = LOAD;
      end
    end else begin
      case (state_q)
        READY, DONE: begin
          if (go && loaded_q) begin
            state_d   = START;
            sc_d      = '0;
            cnt_d     = '0;
            timeout_d = 1'b0;
          end
        end
        START: begin
          if (sc_q == sc_w'(start_cycles - 1)) begin
            state_d = RUN;
          end else begin
            sc_d = sc_q + sc_w'(1);
          end
        end
        RUN: begin
          if (halt) begin
            state_d = DONE;
          end else if (cnt_q == 16'(max_cycles - 1)) begin
            cnt_d     = 16'(max_cycles);
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      loaded_q   <= 1'b0;
      term_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sc_q       <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      loaded_q   <= loaded_d;
      term_q     <= term_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sc_q       <= sc_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - scoreboard bench for run_controller
module tb_run_controller;

  localparam int DEPTH = 256;
  localparam int SC    = 2;
  localparam int MAXC  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [8:0]  load_data = '0;
  logic        load_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_wdata;
  logic [8:0]  prog_len;
  logic        go = 1'b0;
  logic        start;
  logic        halt = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int compared = 0;
  int mismatched = 0;

  logic [16:0] wq[$];
  logic [16:0] rq[$];
  logic [8:0]  pat[$];
  int          exp_addr;
  logic        done_prev = 1'b0;

  run_controller #(
    .instr_width(9), .imem_depth(DEPTH), .start_cycles(SC), .max_cycles(MAXC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .prog_len(prog_len),
    .go(go), .start(start), .halt(halt), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops expected writes and run results as the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        if (wq.size() == 0) chk("unexpected_write", {15'd0, imem_we, 1'b0}, 32'h0);
        else chk("imem_write", {15'd0, imem_addr, imem_wdata}, {15'd0, wq.pop_front()});
      end
      if (done && !done_prev) begin
        if (rq.size() == 0) chk("unexpected_done", {31'd0, done}, 32'h0);
        else chk("run_result", {15'd0, timeout, cycle_count}, {15'd0, rq.pop_front()});
      end
    end
    done_prev <= done;
  end

  task automatic beat(input logic [8:0] d, input logic last);
    int g;
    g = 0;
    @(negedge clk);
    load_valid = 1'b1; load_data = d; load_last = last;
    while (!load_ready && g < 50) begin @(negedge clk); g++; end
    if (!load_ready) chk("beat_wait", 32'd0, 32'd1);
    else begin
      wq.push_back({exp_addr[7:0], d});
      exp_addr++;
    end
    @(posedge clk); #1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic load_pat(input logic uselast);
    exp_addr = 0;
    foreach (pat[i]) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      beat(pat[i], uselast && (i == pat.size() - 1));
    end
    @(negedge clk);
    chk("ready_drop_after_last", {31'd0, load_ready}, 32'd0);
    chk("prog_len", {23'd0, prog_len}, pat.size());
    chk("busy_in_ready", {31'd0, busy}, 32'd0);
  endtask

  task automatic rand_pat(input int n);
    pat.delete();
    for (int i = 0; i < n; i++) pat.push_back(9'($urandom));
  endtask

  // h = RUN cycle on which halt rises (0: never)
  task automatic run_case(input int h);
    int g; int sc; int k;
    if (h == 0 || h > MAXC) rq.push_back({1'b1, 16'(MAXC)});
    else rq.push_back({1'b0, 16'(h - 1)});
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    g = 0;
    while (!start && g < 20) begin @(negedge clk); g++; end
    sc = 0;
    while (start && sc < 50) begin sc++; @(negedge clk); end
    chk("start_len", sc, SC);
    k = 1; g = 0;
    while (!done && g < 200) begin
      halt = (h != 0) && (k >= h);
      @(negedge clk);
      k++; g++;
    end
    halt = 1'b0;
    chk("run_reached_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("start_low_in_done", {30'd0, start, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    // reset state
    #2;
    chk("rst_outs", {27'd0, imem_we, start, busy, done, timeout}, 32'd0);
    chk("rst_cnt_len", {7'd0, prog_len, cycle_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, load_ready}, 32'd1);

    // go before any load is ignored
    go = 1'b1; @(negedge clk); go = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (start || busy) seen++; end
    chk("go_unloaded_ignored", seen, 0);

    // test 1: fixed three-word program
    pat.delete();
    pat.push_back(9'h1A0); pat.push_back(9'h0FF); pat.push_back(9'h155);
    load_pat(1'b1);

    // test 2: halt on the 11th RUN cycle
    run_case(11);

    // test 3: budget timeout
    run_case(0);

    // test 6: load and go together in DONE
    @(negedge clk);
    go = 1'b1; load_valid = 1'b1; load_data = 9'h0A5; load_last = 1'b1;
    wq.push_back({8'd0, 9'h0A5});
    @(posedge clk); #1;
    go = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    @(negedge clk);
    chk("t6_done_cleared", {30'd0, done, timeout}, 32'd0);
    chk("t6_count_cleared", {16'd0, cycle_count}, 32'd0);
    seen = 0;
    repeat (5) begin if (start) seen++; @(negedge clk); end
    chk("t6_no_start", seen, 0);
    chk("t6_prog_len", {23'd0, prog_len}, 32'd1);
    run_case(5);

    // test 4: full-depth load without last
    rand_pat(DEPTH);
    load_pat(1'b0);

    // test 5: reset in the middle of a run
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    seen = 0;
    while (!start && seen < 20) begin @(negedge clk); seen++; end
    seen = 0;
    while (start && seen < 20) begin @(negedge clk); seen++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", {28'd0, start, busy, done, imem_we}, 32'd0);
    chk("t5_len_cnt", {7'd0, prog_len, cycle_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (start || busy) seen++; end
    chk("t5_go_ignored", seen, 0);

    // randomized programs and halt points
    repeat (6) begin
      rand_pat($urandom_range(1, 12));
      load_pat(1'b1);
      run_case($urandom_range(1, 24));
    end

    repeat (3) @(negedge clk);
    chk("writes_drained", wq.size(), 0);
    chk("runs_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
